// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the responder memory.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StErr1 = 2'b10,
    StErr2 = 2'b11
  } slv_state_t;

endpackage

// File: rtl/ahb_slave_sram.sv
// Byte array with synchronous write and combinational read.
module ahb_slave_sram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite responder backed by a byte memory: pipelined data phase, optional
// wait states, two-cycle ERROR for out-of-range addresses.
module ahb_lite_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  slv_state_t        st_q;
  logic [3:0]        cnt_q;
  logic              dp_valid_q;
  logic              dp_write_q;
  logic [IdxW-1:0]   dp_idx_q;

  htrans_t           trans;
  logic              accept;
  logic              in_range;
  logic [IdxW-1:0]   haddr_idx;
  logic              completing;
  logic              wr_en;
  logic [IdxW-1:0]   rd_idx;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] fwd_data;

  assign trans      = htrans_t'(HTRANS);
  assign accept     = HSEL && HREADY && (trans == TransNonseq || trans == TransSeq);
  assign in_range   = ({1'b0, HADDR} < (ADDR_W + 1)'(DEPTH));
  assign haddr_idx  = HADDR[IdxW-1:0];
  // Only in-range transfers are ever pending, so an IDLE-state pending phase completes now.
  assign completing = dp_valid_q && (st_q == StIdle);
  assign wr_en      = completing && dp_write_q;
  assign rd_idx     = (st_q == StWait) ? dp_idx_q : haddr_idx;
  // A write committing on the same edge has not reached the array yet.
  assign fwd_data   = (wr_en && dp_idx_q == haddr_idx) ? HWDATA : mem_rdata;

  ahb_slave_sram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IdxW)
  ) u_sram (
    .clk   (HCLK),
    .we    (wr_en),
    .waddr (dp_idx_q),
    .wdata (HWDATA),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      st_q       <= StIdle;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      HREADYOUT  <= 1'b1;
      HRESP      <= HRESP_OKAY;
      HRDATA     <= '0;
    end else begin
      unique case (st_q)
        StIdle, StErr2: begin
          st_q      <= StIdle;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
          if (completing) dp_valid_q <= 1'b0;
          if (accept) begin
            if (in_range) begin
              dp_valid_q <= 1'b1;
              dp_write_q <= HWRITE;
              dp_idx_q   <= haddr_idx;
              if (WAIT_STATES == 0) begin
                if (!HWRITE) HRDATA <= fwd_data;
              end else begin
                st_q      <= StWait;
                cnt_q     <= 4'(WAIT_STATES);
                HREADYOUT <= 1'b0;
              end
            end else begin
              st_q      <= StErr1;
              HREADYOUT <= 1'b0;
              HRESP     <= HRESP_ERROR;
              HRDATA    <= '0;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            st_q      <= StIdle;
            HREADYOUT <= 1'b1;
            if (!dp_write_q) HRDATA <= mem_rdata;
          end
        end
        StErr1: begin
          st_q      <= StErr2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Directed bench: three responders (0, 3 and 2 wait states) on shared bus inputs.
module tb_ahb_lite_slave_mem;

  logic       HCLK;
  logic       HRESET;
  logic [2:0] hsel;
  logic [20:0] haddr;
  logic       hwrite;
  logic [1:0] htrans;
  logic [7:0] hwdata;
  logic [2:0] hready_w;
  logic [2:0] hreadyout_w;
  logic [2:0] hresp_w;
  logic [7:0] hrdata_w [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_lite_slave_mem #(
      .ADDR_W      (21),
      .DATA_W      (8),
      .DEPTH       (1024),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HSEL      (hsel[g]),
      .HADDR     (haddr),
      .HWRITE    (hwrite),
      .HTRANS    (htrans),
      .HWDATA    (hwdata),
      .HREADY    (hready_w[g]),
      .HREADYOUT (hreadyout_w[g]),
      .HRESP     (hresp_w[g]),
      .HRDATA    (hrdata_w[g])
    );
    assign hready_w[g] = hreadyout_w[g];
  end

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    hsel   = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  // Single non-pipelined transfer; reports read data, low-ready cycles and error.
  task automatic xfer(input int d, input logic wr, input logic [20:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output int waits, output logic err);
    hsel    = '0;
    hsel[d] = 1'b1;
    htrans  = 2'b10;
    haddr   = a;
    hwrite  = wr;
    step();
    bus_idle();
    hwdata = wd;
    waits  = 0;
    err    = 1'b0;
    while (hreadyout_w[d] !== 1'b1 && waits < 50) begin
      if (hresp_w[d] === 1'b1) err = 1'b1;
      waits++;
      step();
    end
    rd = hrdata_w[d];
    if (hresp_w[d] === 1'b1) err = 1'b1;
    step();
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    bus_idle();
    haddr  = '0;
    hwdata = '0;
    step();
    step();
    HRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hreadyout_w[i] !== 1'b1 || hresp_w[i] !== 1'b0 || hrdata_w[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset[%0d]: got rdy=%b resp=%b rdata=%h expected 1 0 00", i,
                 hreadyout_w[i], hresp_w[i], hrdata_w[i]);
      end
    end
  endtask

  task automatic test_forward();
    hsel   = 3'b001;
    htrans = 2'b10;
    haddr  = 21'h010;
    hwrite = 1'b1;
    step();
    hwdata = 8'h5A;
    hwrite = 1'b0;
    checks++;
    if (hreadyout_w[0] !== 1'b1 || hresp_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL fwd_write_phase: got rdy=%b resp=%b expected 1 0", hreadyout_w[0], hresp_w[0]);
    end
    step();
    bus_idle();
    checks++;
    if (hreadyout_w[0] !== 1'b1 || hresp_w[0] !== 1'b0 || hrdata_w[0] !== 8'h5A) begin
      errors++;
      $display("FAIL fwd_read: got rdy=%b resp=%b rdata=%h expected 1 0 5a", hreadyout_w[0],
               hresp_w[0], hrdata_w[0]);
    end
    step();
  endtask

  task automatic test_idle_busy();
    logic [7:0] rd;
    int         w;
    logic       e;
    hwdata = 8'hFF;
    haddr  = 21'h010;
    for (int i = 0; i < 3; i++) begin
      hsel   = (i == 2) ? 3'b000 : 3'b001;
      htrans = (i == 0) ? 2'b01 : ((i == 1) ? 2'b00 : 2'b10);
      hwrite = 1'b1;
      step();
      checks++;
      if (hreadyout_w[0] !== 1'b1 || hresp_w[0] !== 1'b0) begin
        errors++;
        $display("FAIL idle_busy[%0d]: got rdy=%b resp=%b expected 1 0", i, hreadyout_w[0],
                 hresp_w[0]);
      end
    end
    bus_idle();
    step();
    xfer(0, 1'b0, 21'h010, 8'h00, rd, w, e);
    checks++;
    if (rd !== 8'h5A || e !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy_mem: got rdata=%h err=%b expected 5a 0", rd, e);
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      hsel   = 3'b001;
      htrans = (i == 0) ? 2'b10 : 2'b11;
      haddr  = 21'h020 + 21'(i);
      hwrite = 1'b1;
      step();
      hwdata = exp[i];
    end
    bus_idle();
    step();
    for (int i = 0; i < 4; i++) begin
      hsel   = 3'b001;
      htrans = (i == 0) ? 2'b10 : 2'b11;
      haddr  = 21'h020 + 21'(i);
      hwrite = 1'b0;
      step();
      checks++;
      if (hreadyout_w[0] !== 1'b1 || hrdata_w[0] !== exp[i]) begin
        errors++;
        $display("FAIL burst_read[%0d]: got rdy=%b rdata=%h expected 1 %h", i, hreadyout_w[0],
                 hrdata_w[0], exp[i]);
      end
    end
    bus_idle();
    step();
  endtask

  task automatic test_error();
    logic [7:0] rd;
    int         w;
    logic       e;
    xfer(0, 1'b1, 21'h000, 8'h77, rd, w, e);
    xfer(0, 1'b1, 21'h3FF, 8'h66, rd, w, e);
    xfer(0, 1'b0, 21'h400, 8'h00, rd, w, e);
    checks++;
    if (e !== 1'b1 || w != 1 || rd !== 8'h00) begin
      errors++;
      $display("FAIL err_read_400: got err=%b waits=%0d rdata=%h expected 1 1 00", e, w, rd);
    end
    xfer(0, 1'b1, 21'h400, 8'hEE, rd, w, e);
    checks++;
    if (e !== 1'b1 || w != 1) begin
      errors++;
      $display("FAIL err_write_400: got err=%b waits=%0d expected 1 1", e, w);
    end
    xfer(0, 1'b1, 21'h1FFFFF, 8'hDD, rd, w, e);
    checks++;
    if (e !== 1'b1 || w != 1) begin
      errors++;
      $display("FAIL err_write_1fffff: got err=%b waits=%0d expected 1 1", e, w);
    end
    xfer(0, 1'b0, 21'h000, 8'h00, rd, w, e);
    checks++;
    if (rd !== 8'h77 || e !== 1'b0 || w != 0) begin
      errors++;
      $display("FAIL err_keep_000: got rdata=%h err=%b waits=%0d expected 77 0 0", rd, e, w);
    end
    xfer(0, 1'b0, 21'h3FF, 8'h00, rd, w, e);
    checks++;
    if (rd !== 8'h66 || e !== 1'b0) begin
      errors++;
      $display("FAIL err_keep_3ff: got rdata=%h err=%b expected 66 0", rd, e);
    end
  endtask

  task automatic test_wait();
    logic [7:0] rd;
    int         w;
    logic       e;
    xfer(1, 1'b1, 21'h3FF, 8'hC3, rd, w, e);
    checks++;
    if (w != 3 || e !== 1'b0) begin
      errors++;
      $display("FAIL wait_write: got waits=%0d err=%b expected 3 0", w, e);
    end
    step();
    xfer(1, 1'b0, 21'h3FF, 8'h00, rd, w, e);
    checks++;
    if (w != 3 || e !== 1'b0 || rd !== 8'hC3) begin
      errors++;
      $display("FAIL wait_read: got waits=%0d err=%b rdata=%h expected 3 0 c3", w, e, rd);
    end
  endtask

  task automatic test_reset_wait();
    logic [7:0] rd;
    int         w;
    logic       e;
    xfer(2, 1'b1, 21'h030, 8'h9A, rd, w, e);
    xfer(2, 1'b0, 21'h030, 8'h00, rd, w, e);
    checks++;
    if (rd !== 8'h9A || w != 2) begin
      errors++;
      $display("FAIL rstw_setup: got rdata=%h waits=%0d expected 9a 2", rd, w);
    end
    hsel   = 3'b100;
    htrans = 2'b10;
    haddr  = 21'h030;
    hwrite = 1'b1;
    step();
    bus_idle();
    hwdata = 8'h55;
    checks++;
    if (hreadyout_w[2] !== 1'b0) begin
      errors++;
      $display("FAIL rstw_in_wait: got rdy=%b expected 0", hreadyout_w[2]);
    end
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    checks++;
    if (hreadyout_w[2] !== 1'b1 || hresp_w[2] !== 1'b0 || hrdata_w[2] !== 8'h00) begin
      errors++;
      $display("FAIL rstw_after: got rdy=%b resp=%b rdata=%h expected 1 0 00", hreadyout_w[2],
               hresp_w[2], hrdata_w[2]);
    end
    step();
    xfer(2, 1'b0, 21'h030, 8'h00, rd, w, e);
    checks++;
    if (rd !== 8'h9A || e !== 1'b0) begin
      errors++;
      $display("FAIL rstw_dropped: got rdata=%h err=%b expected 9a 0", rd, e);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_idle_busy();
    test_burst();
    test_error();
    test_wait();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
